// File: rtl/power_sequencer.sv
// power_sequencer: brings three supply stages up in order, watches their good signals and
// shuts them down in reverse. The optional AUTO_RETRY_EN build retries after a fault, up to three attempts in total.
module power_sequencer #(
  parameter int STAGE_TIMEOUT  = 4160000,
  parameter int SETTLE_DELAY   = 416000,
  parameter int SHUTDOWN_DELAY = 41600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_clearFault,
  input  logic [2:0] i_stageGood,
  output logic [2:0] o_stageEnable,
  output logic       o_sequenceDone,
  output logic       o_fault,
  output logic [1:0] o_faultStage,
  output logic       o_faultType,
  output logic [2:0] o_state
);

  localparam int MAX_AB    = (STAGE_TIMEOUT > SETTLE_DELAY) ? STAGE_TIMEOUT : SETTLE_DELAY;
  localparam int MAX_DELAY = (MAX_AB > SHUTDOWN_DELAY) ? MAX_AB : SHUTDOWN_DELAY;
  localparam int CW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic [CW-1:0] TIMEOUT_LAST  = CW'(STAGE_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST   = CW'(SETTLE_DELAY - 1);
  localparam logic [CW-1:0] SHUTDOWN_LAST = CW'(SHUTDOWN_DELAY - 1);
  localparam logic [CW-1:0] COUNT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAMP     = 3'd1,
    SETTLE   = 3'd2,
    RUNNING  = 3'd3,
    SHUTDOWN = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t        stateReg;
  logic [1:0]    stageIdx;
  logic [CW-1:0] countReg;

  logic          goodK;
  logic [CW-1:0] countInc;
  logic [1:0]    stageUp;
  logic [1:0]    stageDown;
  logic [1:0]    firstLow;
  logic          faultHit;
  logic [1:0]    faultStageNow;
  logic          faultTypeNow;

`ifdef AUTO_RETRY_EN
  logic [1:0] retryCount;
  logic       retryArmed;
`endif

  assign goodK     = i_stageGood[stageIdx];
  assign countInc  = (countReg == COUNT_MAX) ? countReg : countReg + 1'b1;
  assign stageUp   = stageIdx + 2'd1;
  assign stageDown = stageIdx - 2'd1;
  assign o_state   = stateReg;

  // Lowest-numbered stage that has lost good while running.
  always_comb begin
    firstLow = 2'd3;
    if (!i_stageGood[1]) firstLow = 2'd2;
    if (!i_stageGood[0]) firstLow = 2'd1;
  end

  always_comb begin
    faultHit      = 1'b0;
    faultStageNow = stageUp;
    faultTypeNow  = 1'b0;
    case (stateReg)
      RAMP:    faultHit = !goodK && (countReg == TIMEOUT_LAST);
      SETTLE: begin
        faultHit     = !goodK;
        faultTypeNow = 1'b1;
      end
      RUNNING: begin
        faultHit      = (i_stageGood != 3'b111);
        faultTypeNow  = 1'b1;
        faultStageNow = firstLow;
      end
      default: faultHit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateReg       <= IDLE;
      stageIdx       <= 2'd0;
      countReg       <= '0;
      o_stageEnable  <= 3'b000;
      o_sequenceDone <= 1'b0;
      o_fault        <= 1'b0;
      o_faultStage   <= 2'd0;
      o_faultType    <= 1'b0;
`ifdef AUTO_RETRY_EN
      retryCount     <= 2'd0;
      retryArmed     <= 1'b0;
`endif
    end else if (faultHit) begin
      // Only the first fault is recorded; shutdown starts at the stage being worked on.
      o_fault <= 1'b1;
      if (!o_fault) begin
        o_faultStage <= faultStageNow;
        o_faultType  <= faultTypeNow;
      end
      o_sequenceDone          <= 1'b0;
      o_stageEnable[stageIdx] <= 1'b0;
      stateReg                <= SHUTDOWN;
      countReg                <= '0;
`ifdef AUTO_RETRY_EN
      if (retryCount != 2'd3) retryCount <= retryCount + 2'd1;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
`ifdef AUTO_RETRY_EN
          if (i_enable && (!o_fault || retryArmed)) begin
            stageIdx         <= 2'd0;
            o_stageEnable[0] <= 1'b1;
            stateReg         <= RAMP;
            countReg         <= '0;
            retryArmed       <= 1'b0;
          end else if (o_fault) begin
            stateReg   <= FAULT;
            retryArmed <= 1'b0;
            countReg   <= '0;
          end
`else
          if (i_enable && !o_fault) begin
            stageIdx         <= 2'd0;
            o_stageEnable[0] <= 1'b1;
            stateReg         <= RAMP;
            countReg         <= '0;
          end
`endif
        end
        RAMP: begin
          if (!i_enable) begin
            o_stageEnable[stageIdx] <= 1'b0;
            stateReg                <= SHUTDOWN;
            countReg                <= '0;
          end else if (goodK) begin
            stateReg <= SETTLE;
            countReg <= '0;
          end else begin
            countReg <= countInc;
          end
        end
        SETTLE: begin
          if (!i_enable) begin
            o_stageEnable[stageIdx] <= 1'b0;
            stateReg                <= SHUTDOWN;
            countReg                <= '0;
          end else if (countReg == SETTLE_LAST) begin
            countReg <= '0;
            if (stageIdx == 2'd2) begin
              stateReg       <= RUNNING;
              o_sequenceDone <= 1'b1;
`ifdef AUTO_RETRY_EN
              retryCount     <= 2'd0;
`endif
            end else begin
              stageIdx               <= stageUp;
              o_stageEnable[stageUp] <= 1'b1;
              stateReg               <= RAMP;
            end
          end else begin
            countReg <= countInc;
          end
        end
        RUNNING: begin
          if (!i_enable) begin
            o_sequenceDone   <= 1'b0;
            o_stageEnable[2] <= 1'b0;
            stageIdx         <= 2'd2;
            stateReg         <= SHUTDOWN;
            countReg         <= '0;
          end
        end
        SHUTDOWN: begin
          // Good-signal drops are expected here and deliberately not monitored.
          if (countReg == SHUTDOWN_LAST) begin
            countReg <= '0;
            if (stageIdx != 2'd0) begin
              stageIdx                 <= stageDown;
              o_stageEnable[stageDown] <= 1'b0;
            end else begin
              stateReg <= o_fault ? FAULT : IDLE;
            end
          end else begin
            countReg <= countInc;
          end
        end
        FAULT: begin
          if (i_clearFault && !i_enable) begin
            o_fault      <= 1'b0;
            o_faultStage <= 2'd0;
            o_faultType  <= 1'b0;
            stateReg     <= IDLE;
            countReg     <= '0;
`ifdef AUTO_RETRY_EN
            retryCount   <= 2'd0;
          end else if (i_enable && (retryCount != 2'd3)) begin
            if (countReg == TIMEOUT_LAST) begin
              stateReg   <= IDLE;
              retryArmed <= 1'b1;
              countReg   <= '0;
            end else begin
              countReg <= countInc;
            end
`endif
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer: randomized rail delays, expected enable edges derived arithmetically.
module tb_power_sequencer;
  localparam int TO = 100;
  localparam int ST = 10;
  localparam int SD = 5;
`ifdef AUTO_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clearFault = 1'b0;
  logic [2:0] good = 3'b000;
  logic [2:0] en;
  logic       done;
  logic       fault;
  logic [1:0] fStage;
  logic       fType;
  logic [2:0] state;

  always #5 clk = ~clk;

  power_sequencer #(
    .STAGE_TIMEOUT(TO),
    .SETTLE_DELAY(ST),
    .SHUTDOWN_DELAY(SD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_enable(enable),
    .i_clearFault(clearFault),
    .i_stageGood(good),
    .o_stageEnable(en),
    .o_sequenceDone(done),
    .o_fault(fault),
    .o_faultStage(fStage),
    .o_faultType(fType),
    .o_state(state)
  );

  typedef struct {
    int         t;
    logic [2:0] v;
  } ev_t;

  ev_t        seen[$];
  ev_t        want[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         onCnt[3];
  int         delay[3];
  bit         stuck[3];
  bit         dropped[3];
  int         eAt[3];
  int         runAt;
  logic [2:0] prevEn = 3'b000;
  logic       prevDone = 1'b0;
  logic       prevFault = 1'b0;
  int         doneRise, doneFall, faultRise;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: sample outputs after the edge, log enable changes, advance the rail model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (en !== prevEn) begin
      ev_t e;
      e.t = cyc;
      e.v = en;
      seen.push_back(e);
    end
    for (int n = 0; n < 3; n++) begin
      if (en[n] === 1'b1 && prevEn[n] !== 1'b1) onCnt[n] = 0;
      else if (en[n] === 1'b1) onCnt[n]++;
    end
    prevEn = en;
    if (fault === 1'b1 && prevFault !== 1'b1) faultRise = cyc;
    prevFault = fault;
    if (done === 1'b1 && prevDone !== 1'b1) doneRise = cyc;
    if (done !== 1'b1 && prevDone === 1'b1) doneFall = cyc;
    prevDone = done;
    for (int n = 0; n < 3; n++)
      good[n] = (en[n] === 1'b1) && (onCnt[n] >= delay[n]) && !stuck[n] && !dropped[n];
  endtask

  task automatic runFor(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expectEv(input int t, input logic [2:0] v);
    ev_t e;
    e.t = t;
    e.v = v;
    want.push_back(e);
  endtask

  task automatic compareEv(input string tag);
    check({tag, "_events"}, seen.size(), want.size());
    for (int i = 0; i < want.size() && i < seen.size(); i++) begin
      check($sformatf("%s_t%0d", tag, i), seen[i].t, want[i].t);
      check($sformatf("%s_v%0d", tag, i), 32'(seen[i].v), 32'(want[i].v));
    end
    seen.delete();
    want.delete();
  endtask

  task automatic clearScenario();
    for (int n = 0; n < 3; n++) begin
      stuck[n] = 1'b0;
      dropped[n] = 1'b0;
      delay[n] = $urandom_range(1, 60);
    end
    doneRise = -1;
    doneFall = -1;
    faultRise = -1;
    seen.delete();
    want.delete();
  endtask

  // Enable edge of each stage: good is sampled one edge after the rail asserts it,
  // and the next stage follows a full settle period after that.
  task automatic startUp();
    enable = 1'b1;
    eAt[0] = cyc + 1;
    for (int n = 1; n < 3; n++) eAt[n] = eAt[n-1] + delay[n-1] + 1 + ST;
    runAt = eAt[2] + delay[2] + 1 + ST;
  endtask

  task automatic clearRules(input string tag, input int expStage);
    if (enable) begin
      clearFault = 1'b1;
      tick();
      clearFault = 1'b0;
      tick();
      check({tag, "_clr_held_fault"}, 32'(fault), 1);
      check({tag, "_clr_held_state"}, 32'(state), 5);
      check({tag, "_clr_held_stage"}, 32'(fStage), 32'(expStage));
    end
    enable = 1'b0;
    clearFault = 1'b1;
    tick();
    clearFault = 1'b0;
    check({tag, "_clr_fault"}, 32'(fault), 0);
    check({tag, "_clr_state"}, 32'(state), 0);
    check({tag, "_clr_stage"}, 32'(fStage), 0);
    check({tag, "_clr_type"}, 32'(fType), 0);
    tick();
  endtask

  initial begin
    int         c, f, s, lowest;
    logic [2:0] mask;
    bit         fallWith;

    clearScenario();
    rst = 1'b1;
    runFor(2);
    rst = 1'b0;
    tick();
    seen.delete();
    check("reset_en", 32'(en), 0);
    check("reset_state", 32'(state), 0);
    check("reset_done", 32'(done), 0);
    check("reset_fault", 32'(fault), 0);
    check("reset_stage", 32'(fStage), 0);
    check("reset_type", 32'(fType), 0);
    $display("txn reset: en=%b state=%0d", en, state);

    // Power up, then either drop rails while running or turn off in order.
    for (int it = 0; it < 5; it++) begin
      clearScenario();
      startUp();
      expectEv(eAt[0], 3'b001);
      expectEv(eAt[1], 3'b011);
      expectEv(eAt[2], 3'b111);
      runFor(runAt - cyc + 2);
      check("up_done", 32'(done), 1);
      check("up_done_time", doneRise, runAt);
      check("up_state", 32'(state), 3);
      check("up_fault", 32'(fault), 0);
      compareEv("up");
      $display("txn %0d powerup delays=%0d/%0d/%0d running_at=%0d", it, delay[0], delay[1], delay[2], runAt);
      runFor($urandom_range(0, 20));
      if (it == 1 || (it > 1 && $urandom_range(0, 1) == 1)) begin
        c = cyc;
        enable = 1'b0;
        expectEv(c + 1, 3'b011);
        expectEv(c + 1 + SD, 3'b001);
        expectEv(c + 1 + 2 * SD, 3'b000);
        runFor(3 * SD + 3);
        check("off_state", 32'(state), 0);
        check("off_fault", 32'(fault), 0);
        check("off_done_fall", doneFall, c + 1);
        compareEv("off");
        $display("txn %0d orderly_off at=%0d state=%0d", it, c + 1, state);
      end else begin
        mask = (it == 0) ? 3'b101 : 3'($urandom_range(1, 7));
        lowest = mask[0] ? 1 : (mask[1] ? 2 : 3);
        c = cyc;
        for (int n = 0; n < 3; n++) if (mask[n]) dropped[n] = 1'b1;
        good = good & ~mask;
        expectEv(c + 1, 3'b011);
        expectEv(c + 1 + SD, 3'b001);
        expectEv(c + 1 + 2 * SD, 3'b000);
        runFor(3 * SD + 3);
        check("drop_fault_time", faultRise, c + 1);
        check("drop_stage", 32'(fStage), 32'(lowest));
        check("drop_type", 32'(fType), 1);
        check("drop_done_fall", doneFall, c + 1);
        check("drop_state", 32'(state), 5);
        compareEv("drop");
        $display("txn %0d dropout mask=%b stage=%0d", it, mask, fStage);
        clearRules("drop", lowest);
      end
    end

    // Ramp timeouts, the first on stage 2; one case also drops enable on the timeout edge.
    for (int it = 0; it < 4; it++) begin
      clearScenario();
      s = (it == 0) ? 1 : $urandom_range(0, 2);
      fallWith = (it == 3);
      stuck[s] = 1'b1;
      startUp();
      f = eAt[s] + TO;
      for (int n = 0; n <= s; n++) expectEv(eAt[n], 3'((1 << (n + 1)) - 1));
      for (int j = 0; j <= s; j++) expectEv(f + j * SD, 3'((1 << (s - j)) - 1));
      if (fallWith) begin
        runFor(f - 1 - cyc);
        enable = 1'b0;
      end
      runFor(f + (s + 1) * SD + 2 - cyc);
      check("to_fault_time", faultRise, f);
      check("to_stage", 32'(fStage), 32'(s + 1));
      check("to_type", 32'(fType), 0);
      check("to_state", 32'(state), 5);
      check("to_en", 32'(en), 0);
      compareEv("to");
      $display("txn timeout stage=%0d fault_at=%0d enable_fall=%0d", s + 1, f, fallWith);
      clearRules("to", s + 1);
    end

    // Reset while stage 2 is ramping.
    clearScenario();
    startUp();
    runFor(eAt[1] + 3 - cyc);
    check("rr_pre_en", 32'(en), 3);
    rst = 1'b1;
    tick();
    check("rr_en", 32'(en), 0);
    check("rr_state", 32'(state), 0);
    check("rr_done", 32'(done), 0);
    check("rr_fault", 32'(fault), 0);
    rst = 1'b0;
    enable = 1'b0;
    tick();
    $display("txn reset_mid_ramp en=%b state=%0d", en, state);

    // Stage 1 never good with enable held: retry attempts, then stay in FAULT.
    clearScenario();
    stuck[0] = 1'b1;
    enable = 1'b1;
    c = cyc + 1;
    f = c;
    for (int a = 0; a < ATTEMPTS; a++) begin
      expectEv(c, 3'b001);
      f = c + TO;
      expectEv(f, 3'b000);
      c = f + SD + TO + 1;
    end
    runFor(f + SD + 2 * TO - cyc);
    check("hold_state", 32'(state), 5);
    check("hold_stage", 32'(fStage), 1);
    check("hold_type", 32'(fType), 0);
    check("hold_fault", 32'(fault), 1);
    check("hold_en", 32'(en), 0);
    compareEv("hold");
    $display("txn held_enable attempts=%0d state=%0d stage=%0d", ATTEMPTS, state, fStage);
    clearRules("hold", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Sequences the three supply stages (S1 12V; S2 5V/3V3; S3 3V3ADC/FPGA) up in order and down in reverse order.
- Inputs are the per-stage good signals from the rail good generators; outputs are the per-stage enables to the regulators.
- Enforces a power-up timeout and a settle time per stage.
- Latches the first fault (stage and type) and performs an orderly reverse shutdown. Sits between the rail monitors and the regulator enable pins.

Parameters:
- STAGE_TIMEOUT, 4160000: clocks allowed from stage enable to stage good (1 s at 4.16 MHz).
- SETTLE_DELAY, 416000: clocks the stage must stay good before the next stage is enabled (100 ms).
- SHUTDOWN_DELAY, 41600: clocks between successive stage disables during shutdown (10 ms).
- Counter width is $clog2 of the largest parameter.

Ports:
- i_clk  input  1  system clock (internal oscillator, 4.16 MHz).
- i_rst  input  1  synchronous reset, active-high.
- i_enable  input  1  level: 1 requests power-up/hold, 0 requests orderly shutdown.
- i_clearFault  input  1  single-cycle pulse; clears a latched fault.
- i_stageGood  input  3  bit n = stage n+1 good.
- o_stageEnable  output  3  bit n = enable for stage n+1.
- o_sequenceDone  output  1  high while all stages are up and settled.
- o_fault  output  1  latched fault flag.
- o_faultStage  output  2  0 = none, 1..3 = stage that faulted.
- o_faultType  output  1  0 = power-up timeout, 1 = dropout after good.
- o_state  output  3  current FSM state encoding, for debug/UART.

Behaviour:
- Reset is synchronous: i_rst sampled high forces the following on the next edge, including mid-sequence (enables drop immediately, with no orderly shutdown):
  - state = IDLE, all counters 0
  - o_stageEnable = 3'b000, o_sequenceDone = 0, o_fault = 0, o_faultStage = 0, o_faultType = 0
- State encodings: IDLE = 0, RAMP = 1, SETTLE = 2, RUNNING = 3, SHUTDOWN = 4, FAULT = 5.
- An internal stage index k (0..2) selects the stage being worked on.
- IDLE:
  - If i_enable = 1 and o_fault = 0: set k = 0, o_stageEnable[0] = 1 on the same edge, go to RAMP, clear the counter.
- RAMP:
  - Counter increments each cycle.
  - If i_stageGood[k] = 1: go to SETTLE, clear the counter.
  - Else if counter == STAGE_TIMEOUT-1: fault, with o_faultStage = k+1 and o_faultType = 0.
- SETTLE:
  - If i_stageGood[k] drops: fault, with type 1 and stage k+1.
  - When counter == SETTLE_DELAY-1:
    - if k < 2: k = k+1, set o_stageEnable[k] (the new k), go to RAMP, clear the counter;
    - if k == 2: go to RUNNING.
- RUNNING:
  - o_sequenceDone = 1.
  - Any i_stageGood bit low: fault, with type 1 and the lowest-numbered failing stage.
  - i_enable = 0: go to SHUTDOWN with k = 2.
- SHUTDOWN:
  - On entry, clear o_stageEnable[k] and clear the counter.
  - After SHUTDOWN_DELAY cycles: decrement k and clear the next bit.
  - After bit 0 is cleared and SHUTDOWN_DELAY elapses: go to IDLE (or to FAULT if o_fault = 1).
  - Good-signal drops are ignored during SHUTDOWN.
- Fault entry (from RAMP, SETTLE or RUNNING):
  - o_fault = 1; o_faultStage/o_faultType latched on the same edge.
  - o_sequenceDone = 0 on the next cycle.
  - Go to SHUTDOWN starting from the highest currently enabled stage.
  - Only the first fault is latched; later faults never overwrite it.
- FAULT:
  - All enables stay 0.
  - i_clearFault = 1 and i_enable = 0: clear o_fault/o_faultStage/o_faultType and go to IDLE.
  - i_clearFault while i_enable = 1 is ignored, so a held enable cannot cause a restart.
- Priority when events coincide in one cycle: i_rst > fault detection > i_enable deassert > timer expiry.
  - Example: timeout and i_enable falling together record a timeout fault.
- i_enable deasserted during RAMP or SETTLE: go to SHUTDOWN from stage k; no fault.
- Counters saturate and never wrap.

Optional Feature:
- AUTO_RETRY_EN defined:
  - After a fault completes shutdown, the block waits STAGE_TIMEOUT cycles in FAULT, then retries from IDLE automatically, up to 3 attempts.
  - A 2-bit retry count is cleared on RUNNING, reset, or i_clearFault.
  - o_fault stays latched from the first fault until cleared.
  - After the 3rd failure the block stays in FAULT as in the non-retry behaviour.
- AUTO_RETRY_EN undefined: no retry logic or counter; FAULT is exited only via i_clearFault.

Test Plan (bench uses STAGE_TIMEOUT = 100, SETTLE_DELAY = 10, SHUTDOWN_DELAY = 5):
1. Nominal power-up: i_enable = 1, each i_stageGood bit rises 20 clocks after its enable. Required: enables 001 -> 011 -> 111, each step spaced 10 settle clocks after good; o_sequenceDone = 1; o_state = 3.
2. Ramp timeout: stage 2 good never rises. Required: fault exactly 100 clocks after o_stageEnable[1] rises; o_faultStage = 2, o_faultType = 0; enables 011 -> 001 -> 000 with 5-clock spacing; o_state = 5.
3. Dropout in RUNNING: drop i_stageGood[0] and [2] in the same cycle. Required: o_faultStage = 1, o_faultType = 1; o_sequenceDone = 0 next cycle; reverse shutdown.
4. Clear rules: pulse i_clearFault with i_enable = 1 -> fault persists. Pulse with i_enable = 0 -> o_fault = 0, o_state = 0.
5. Orderly off and reset: i_enable = 0 in RUNNING -> 111 -> 011 -> 001 -> 000 at 5-clock spacing, no fault. Separately, assert i_rst mid-RAMP -> all outputs 0 on the next edge.
6. AUTO_RETRY_EN build: stage 1 never good. Required: three attempts, then the block stays in FAULT with o_faultStage = 1.
